// File: rtl/if_fetch_stage.sv
// if_fetch_stage: instruction-fetch stage and IF/ID pipeline register for the
// five-stage MIPS pipeline. Owns the PC, talks to instruction memory over a
// request/acknowledge handshake and presents {PC+4, instruction, valid} to ID.
//
// Optional feature macro: DELAY_SLOT_EN
//   defined   -> MIPS branch delay slot; a redirect never flushes IF/ID, and a
//                redirect seen while a fetch is still outstanding is parked in
//                a pending-redirect register until the slot instruction lands.
//   undefined -> no delay slot; a redirect flushes IF/ID with NOP_INSTR.

module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_data,
    input  logic        stall_ctrl,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    output logic [31:0] pc,
    output logic [31:0] if_id_pc4,
    output logic [31:0] if_id_instr,
    output logic        if_id_valid
);

    // FETCH: a request is outstanding for pc.
    // HOLD : the word for pc arrived during a stall and sits in hold_buf.
    typedef enum logic [0:0] {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [31:0] pc_next;
    logic [31:0] if_id_pc4_next;
    logic [31:0] if_id_instr_next;
    logic        if_id_valid_next;
    logic [31:0] hold_buf;
    logic [31:0] hold_buf_next;

    logic        stall;
    logic        redirect;
    logic [31:0] redirect_target;
    logic [31:0] pc_plus4;

`ifdef DELAY_SLOT_EN
    logic        pend_valid;
    logic        pend_valid_next;
    logic [31:0] pend_target;
    logic [31:0] pend_target_next;
`endif

    // Stall merge and redirect selection; a stalled ID stage cannot redirect,
    // and a branch outranks a jump if both show up together.
    always_comb begin
        stall           = stall_data | stall_ctrl;
        redirect        = (branch_taken | jump) & ~stall;
        redirect_target = (branch_taken ? branch_target : jump_target) & 32'hFFFF_FFFC;
        pc_plus4        = pc + 32'd4;
    end

    // Memory request: only while waiting for a word, and never during reset.
    always_comb begin
        imem_req  = (state == FETCH) & ~rst;
        imem_addr = {pc[31:2], 2'b00};
    end

    // Next-state and next-register logic for the fetch FSM and IF/ID.
    always_comb begin
        state_next       = state;
        pc_next          = pc;
        if_id_pc4_next   = if_id_pc4;
        if_id_instr_next = if_id_instr;
        if_id_valid_next = if_id_valid;
        hold_buf_next    = hold_buf;
`ifdef DELAY_SLOT_EN
        pend_valid_next  = pend_valid;
        pend_target_next = pend_target;
`endif

        case (state)
            FETCH: begin
                if (imem_ack) begin
                    if (stall) begin
                        hold_buf_next = imem_rdata;
                        state_next    = HOLD;
                    end else begin
`ifdef DELAY_SLOT_EN
                        if_id_pc4_next   = pc_plus4;
                        if_id_instr_next = imem_rdata;
                        if_id_valid_next = 1'b1;
                        if (pend_valid) begin
                            pc_next         = pend_target;
                            pend_valid_next = 1'b0;
                        end else if (redirect) begin
                            pc_next = redirect_target;
                        end else begin
                            pc_next = pc_plus4;
                        end
`else
                        if (redirect) begin
                            pc_next          = redirect_target;
                            if_id_pc4_next   = 32'h0000_0000;
                            if_id_instr_next = NOP_INSTR;
                            if_id_valid_next = 1'b0;
                        end else begin
                            pc_next          = pc_plus4;
                            if_id_pc4_next   = pc_plus4;
                            if_id_instr_next = imem_rdata;
                            if_id_valid_next = 1'b1;
                        end
`endif
                    end
                end else if (!stall) begin
                    if_id_valid_next = 1'b0;
                    if_id_instr_next = NOP_INSTR;
`ifdef DELAY_SLOT_EN
                    if (redirect && !pend_valid) begin
                        pend_valid_next  = 1'b1;
                        pend_target_next = redirect_target;
                    end
`else
                    if (redirect) begin
                        pc_next = redirect_target;
                    end
`endif
                end
            end

            HOLD: begin
                if (!stall) begin
                    state_next = FETCH;
`ifdef DELAY_SLOT_EN
                    if_id_pc4_next   = pc_plus4;
                    if_id_instr_next = hold_buf;
                    if_id_valid_next = 1'b1;
                    if (pend_valid) begin
                        pc_next         = pend_target;
                        pend_valid_next = 1'b0;
                    end else if (redirect) begin
                        pc_next = redirect_target;
                    end else begin
                        pc_next = pc_plus4;
                    end
`else
                    if (redirect) begin
                        pc_next          = redirect_target;
                        if_id_pc4_next   = 32'h0000_0000;
                        if_id_instr_next = NOP_INSTR;
                        if_id_valid_next = 1'b0;
                    end else begin
                        pc_next          = pc_plus4;
                        if_id_pc4_next   = pc_plus4;
                        if_id_instr_next = hold_buf;
                        if_id_valid_next = 1'b1;
                    end
`endif
                end
            end

            default: begin
                state_next = FETCH;
            end
        endcase
    end

    // State, PC, IF/ID and hold buffer registers with synchronous reset;
    // reset also drops any word or redirect that was in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= FETCH;
            pc          <= RESET_PC;
            if_id_pc4   <= 32'h0000_0000;
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
            hold_buf    <= 32'h0000_0000;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            if_id_pc4   <= if_id_pc4_next;
            if_id_instr <= if_id_instr_next;
            if_id_valid <= if_id_valid_next;
            hold_buf    <= hold_buf_next;
        end
    end

`ifdef DELAY_SLOT_EN
    // Pending-redirect register used while the delay-slot fetch is outstanding.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_valid  <= 1'b0;
            pend_target <= 32'h0000_0000;
        end else begin
            pend_valid  <= pend_valid_next;
            pend_target <= pend_target_next;
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: table-driven directed vectors plus randomized stimulus
// checked against a transaction-level fetch model, for if_fetch_stage built
// without DELAY_SLOT_EN.

module tb_if_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0020;

    logic        clk;
    logic        rst;
    logic        stall_data;
    logic        stall_ctrl;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        imem_ack;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] if_id_pc4;
    logic [31:0] if_id_instr;
    logic        if_id_valid;

    logic        imem_req2;
    logic [31:0] imem_addr2;
    logic [31:0] imem_rdata2;
    logic [31:0] pc2;
    logic [31:0] if_id_pc4_2;
    logic [31:0] if_id_instr2;
    logic        if_id_valid2;

    int checks;
    int failures;

    // Instruction memory contents: a distinct word derived from each address.
    function automatic logic [31:0] memword(input logic [31:0] a);
        return {a[15:0], 16'hC0DE} ^ {16'h0000, a[31:16]};
    endfunction

    assign imem_rdata  = memword(imem_addr);
    assign imem_rdata2 = memword(imem_addr2);

    if_fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst(rst), .stall_data(stall_data), .stall_ctrl(stall_ctrl),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .imem_ack(imem_ack), .pc(pc), .if_id_pc4(if_id_pc4),
        .if_id_instr(if_id_instr), .if_id_valid(if_id_valid)
    );

    if_fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(NOP)) dut_wrap (
        .clk(clk), .rst(rst), .stall_data(stall_data), .stall_ctrl(stall_ctrl),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump(jump), .jump_target(jump_target),
        .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_rdata(imem_rdata2),
        .imem_ack(imem_ack), .pc(pc2), .if_id_pc4(if_id_pc4_2),
        .if_id_instr(if_id_instr2), .if_id_valid(if_id_valid2)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        sd;
        logic        sc;
        logic        br;
        logic [31:0] brt;
        logic        j;
        logic [31:0] jt;
        logic        ack;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic [31:0] exp_pc;
        logic [31:0] exp_pc4;
        logic [31:0] exp_instr;
        logic        exp_valid;
    } vec_t;

    vec_t tbl[13];

    function automatic vec_t mk(input logic sd, input logic sc, input logic br,
                                input logic [31:0] brt, input logic j,
                                input logic [31:0] jt, input logic ack,
                                input logic exp_req, input logic [31:0] exp_addr,
                                input logic [31:0] exp_pc, input logic [31:0] exp_pc4,
                                input logic [31:0] exp_instr, input logic exp_valid);
        vec_t v;
        v.sd = sd; v.sc = sc; v.br = br; v.brt = brt; v.j = j; v.jt = jt;
        v.ack = ack; v.exp_req = exp_req; v.exp_addr = exp_addr;
        v.exp_pc = exp_pc; v.exp_pc4 = exp_pc4; v.exp_instr = exp_instr;
        v.exp_valid = exp_valid;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic sd, input logic sc, input logic br,
                                 input logic [31:0] brt, input logic j,
                                 input logic [31:0] jt, input logic ack);
        stall_data    = sd;
        stall_ctrl    = sc;
        branch_taken  = br;
        branch_target = brt;
        jump          = j;
        jump_target   = jt;
        imem_ack      = ack;
        #1;
    endtask

    task automatic stepEdge();
        @(posedge clk);
        #1;
    endtask

    // Reference model state: the PC, whether a fetched word is parked during
    // a stall, and the IF/ID contents.
    logic [31:0] m_pc;
    logic        m_parked;
    logic [31:0] m_parked_word;
    logic [31:0] m_pc4;
    logic [31:0] m_instr;
    logic        m_valid;

    task automatic modelStep(input logic sd, input logic sc, input logic br,
                             input logic [31:0] brt, input logic j,
                             input logic [31:0] jt, input logic ack);
        logic        st;
        logic        rd;
        logic [31:0] tgt;
        logic        have_word;
        logic [31:0] word;
        st  = sd | sc;
        rd  = (br | j) & ~st;
        tgt = (br ? brt : jt) & 32'hFFFF_FFFC;
        have_word = m_parked | ack;
        word      = m_parked ? m_parked_word : memword(m_pc);
        if (st) begin
            if (!m_parked && ack) begin
                m_parked      = 1'b1;
                m_parked_word = word;
            end
        end else if (have_word) begin
            m_parked = 1'b0;
            if (rd) begin
                m_pc = tgt; m_pc4 = 32'h0; m_instr = NOP; m_valid = 1'b0;
            end else begin
                m_pc4 = m_pc + 32'd4; m_instr = word; m_valid = 1'b1;
                m_pc  = m_pc + 32'd4;
            end
        end else begin
            m_valid = 1'b0;
            m_instr = NOP;
            if (rd) m_pc = tgt;
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;

        tbl[0]  = mk(0,0,0,0,0,0,1,            1, 32'h00, 32'h04,  32'h04,  memword(32'h00), 1);
        tbl[1]  = mk(0,0,0,0,0,0,1,            1, 32'h04, 32'h08,  32'h08,  memword(32'h04), 1);
        tbl[2]  = mk(1,0,0,0,0,0,1,            1, 32'h08, 32'h08,  32'h08,  memword(32'h04), 1);
        tbl[3]  = mk(1,0,0,0,0,0,1,            0, 32'h08, 32'h08,  32'h08,  memword(32'h04), 1);
        tbl[4]  = mk(0,0,0,0,0,0,0,            0, 32'h08, 32'h0C,  32'h0C,  memword(32'h08), 1);
        tbl[5]  = mk(0,0,0,0,0,0,1,            1, 32'h0C, 32'h10,  32'h10,  memword(32'h0C), 1);
        tbl[6]  = mk(0,0,1,32'h40,0,0,1,       1, 32'h10, 32'h40,  32'h00,  NOP,             0);
        tbl[7]  = mk(0,0,0,0,0,0,1,            1, 32'h40, 32'h44,  32'h44,  memword(32'h40), 1);
        tbl[8]  = mk(0,1,1,32'h80,0,0,1,       1, 32'h44, 32'h44,  32'h44,  memword(32'h40), 1);
        tbl[9]  = mk(0,0,0,0,1,32'h101,0,      0, 32'h44, 32'h100, 32'h00,  NOP,             0);
        tbl[10] = mk(0,0,0,0,0,0,0,            1, 32'h100,32'h100, 32'h00,  NOP,             0);
        tbl[11] = mk(0,0,1,32'h300,1,32'h200,0,1, 32'h100,32'h300, 32'h00,  NOP,             0);
        tbl[12] = mk(0,0,0,0,0,0,1,            1, 32'h300,32'h304, 32'h304, memword(32'h300),1);

        // Reset values, including request suppression while rst is high.
        rst = 1'b1;
        applyStimulus(0, 0, 0, 32'h0, 0, 32'h0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_req",   {31'h0, imem_req},    32'h0);
        checkOutput("reset_pc",    pc,                   32'h0);
        checkOutput("reset_pc4",   if_id_pc4,            32'h0);
        checkOutput("reset_instr", if_id_instr,          NOP);
        checkOutput("reset_valid", {31'h0, if_id_valid}, 32'h0);
        checkOutput("reset_pc_wrap", pc2,                32'hFFFF_FFFC);

        // First request right after reset, and PC wrap-around on the second DUT.
        rst = 1'b0;
        #1;
        checkOutput("first_req",  {31'h0, imem_req}, 32'h1);
        checkOutput("first_addr", imem_addr,         32'h0);
        checkOutput("wrap_addr",  imem_addr2,        32'hFFFF_FFFC);
        stepEdge();
        checkOutput("wrap_pc",    pc2,                    32'h0);
        checkOutput("wrap_pc4",   if_id_pc4_2,            32'h0);
        checkOutput("wrap_instr", if_id_instr2,           memword(32'hFFFF_FFFC));
        checkOutput("wrap_valid", {31'h0, if_id_valid2},  32'h1);

        // Re-reset and run the directed table.
        rst = 1'b1;
        stepEdge();
        rst = 1'b0;
        for (int i = 0; i < 13; i++) begin
            applyStimulus(tbl[i].sd, tbl[i].sc, tbl[i].br, tbl[i].brt,
                          tbl[i].j, tbl[i].jt, tbl[i].ack);
            checkOutput($sformatf("v%0d_req", i),  {31'h0, imem_req}, {31'h0, tbl[i].exp_req});
            checkOutput($sformatf("v%0d_addr", i), imem_addr,         tbl[i].exp_addr);
            stepEdge();
            checkOutput($sformatf("v%0d_pc", i),    pc,                   tbl[i].exp_pc);
            checkOutput($sformatf("v%0d_pc4", i),   if_id_pc4,            tbl[i].exp_pc4);
            checkOutput($sformatf("v%0d_instr", i), if_id_instr,          tbl[i].exp_instr);
            checkOutput($sformatf("v%0d_valid", i), {31'h0, if_id_valid}, {31'h0, tbl[i].exp_valid});
        end

        // Reset while a request is outstanding, with an ack in the reset cycle.
        applyStimulus(0, 0, 0, 32'h0, 0, 32'h0, 1'b0);
        stepEdge();
        rst = 1'b1;
        applyStimulus(0, 0, 0, 32'h0, 0, 32'h0, 1'b1);
        checkOutput("rst_mid_req", {31'h0, imem_req}, 32'h0);
        stepEdge();
        checkOutput("rst_mid_pc",    pc,                   32'h0);
        checkOutput("rst_mid_pc4",   if_id_pc4,            32'h0);
        checkOutput("rst_mid_instr", if_id_instr,          NOP);
        checkOutput("rst_mid_valid", {31'h0, if_id_valid}, 32'h0);
        rst = 1'b0;
        applyStimulus(0, 0, 0, 32'h0, 0, 32'h0, 1'b0);
        checkOutput("post_rst_req",  {31'h0, imem_req}, 32'h1);
        checkOutput("post_rst_addr", imem_addr,         32'h0);
        stepEdge();

        // Randomized run against the reference model.
        m_pc = 32'h0; m_parked = 1'b0; m_parked_word = 32'h0;
        m_pc4 = 32'h0; m_instr = NOP; m_valid = 1'b0;
        for (int n = 0; n < 400; n++) begin
            logic        sd, sc, br, j, ack;
            logic [31:0] brt, jt;
            sd  = ($urandom_range(0, 99) < 20);
            sc  = ($urandom_range(0, 99) < 10);
            br  = ($urandom_range(0, 99) < 15);
            j   = ($urandom_range(0, 99) < 10);
            ack = ($urandom_range(0, 99) < 60);
            brt = $urandom();
            jt  = $urandom();
            applyStimulus(sd, sc, br, brt, j, jt, ack);
            checkOutput("rnd_req",  {31'h0, imem_req}, {31'h0, ~m_parked});
            checkOutput("rnd_addr", imem_addr,         m_pc);
            modelStep(sd, sc, br, brt, j, jt, ack);
            stepEdge();
            checkOutput("rnd_pc",    pc,                   m_pc);
            checkOutput("rnd_pc4",   if_id_pc4,            m_pc4);
            checkOutput("rnd_instr", if_id_instr,          m_instr);
            checkOutput("rnd_valid", {31'h0, if_id_valid}, {31'h0, m_valid});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule

// File: doc/if_fetch_stage.md
# if_fetch_stage

Instruction-fetch stage and IF/ID pipeline register for the five-stage MIPS pipeline. Owns the PC, issues requests to instruction memory over a request/acknowledge handshake, and presents PC+4, instruction and valid to the ID stage. Consumes the stall outputs of the data and control hazard units (IF/ID write-zero and PC hold) and the branch/jump redirect resolved in ID.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset (word aligned).
- NOP_INSTR, 32'h0000_0000, instruction word placed in IF/ID on flush/reset.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  reset, synchronous, active-high.
- stall_data  input  1  IF/ID write-zero from data hazard unit.
- stall_ctrl  input  1  IF/ID write-zero from control hazard unit.
- branch_taken  input  1  taken branch resolved in ID this cycle.
- branch_target  input  32  branch destination.
- jump  input  1  jump in ID this cycle.
- jump_target  input  32  jump destination.
- imem_req  output  1  instruction fetch request.
- imem_addr  output  32  fetch address; bits [1:0] always 0.
- imem_rdata  input  32  instruction word, valid when imem_ack=1.
- imem_ack  input  1  response for current imem_addr; may be same-cycle.
- pc  output  32  current fetch PC.
- if_id_pc4  output  32  registered PC+4 of instruction in ID.
- if_id_instr  output  32  registered instruction in ID.
- if_id_valid  output  1  IF/ID holds a real instruction.

## Operation
- stall = stall_data | stall_ctrl. Redirect = (branch_taken | jump) & ~stall; branch_taken wins if both; target = chosen target with bits [1:0] cleared. Redirect inputs are ignored while stall=1.
- stall=1: pc and IF/ID registers hold their values (bubble insertion downstream is the hazard unit's job).
- FSM states: FETCH, HOLD.
- FETCH: imem_req=1, imem_addr=pc; request held until imem_ack.
  - ack, no stall, no redirect: IF/ID <= {pc+4, imem_rdata, 1}; pc <= pc+4; stay FETCH.
  - ack, stall: capture imem_rdata in hold buffer; go HOLD; pc and IF/ID unchanged.
  - ack, redirect: pc <= target; IF/ID <= {0, NOP_INSTR, 0}; stay FETCH (fetched word discarded).
  - no ack, no stall: if_id_valid <= 0, if_id_instr <= NOP_INSTR; redirect, if present, sets pc <= target (address may change before ack; memory answers the current address).
- HOLD: imem_req=0. When stall drops: no redirect -> IF/ID <= {pc+4, buffer, 1}, pc <= pc+4; redirect -> flush IF/ID, pc <= target; both go FETCH.
- PC+4 arithmetic modulo 2^32; pc 32'hFFFF_FFFC advances to 32'h0000_0000.

## Timing
- Reset values: pc=RESET_PC, state FETCH, if_id_pc4=0, if_id_instr=NOP_INSTR, if_id_valid=0, imem_req=0 while rst=1, pending-redirect flag cleared, hold buffer=0.
- First request: imem_req=1 with imem_addr=RESET_PC in the first cycle after rst falls.
- Latency: with same-cycle ack and no stall, one instruction per cycle; IF/ID updates on the edge ending the ack cycle.
- Redirect takes effect at the next edge; target fetched in the following cycle.
- rst mid-request: request abandoned, any ack in the rst cycle ignored, hold buffer and pending redirect discarded.

## Configuration
- DELAY_SLOT_EN defined: MIPS branch delay slot. Redirect never flushes: FETCH+ack+redirect loads fetched word into IF/ID and sets pc <= target; HOLD+redirect loads buffer into IF/ID, pc <= target. Redirect in FETCH without ack latches target in a pending-redirect register; pc keeps fetching the slot; on its ack, IF/ID loads it and pc <= pending target. A second redirect while pending is ignored.
- Undefined: no delay slot; redirect flushes as described in Operation; pending-redirect register absent.

## Test plan
- Reset, same-cycle ack always -> imem_addr 0x0,0x4,0x8 in consecutive cycles; if_id_pc4 0x4,0x8,0xC; if_id_valid=1 from second cycle.
- stall_data high 2 cycles at pc=0x8 -> pc holds 0x8, imem_req=0 in HOLD, IF/ID holds; after release IF/ID gets buffered word, pc=0xC.
- branch_taken, branch_target=0x40 at pc=0x10, no delay slot -> IF/ID flushed (valid=0, NOP), next imem_addr=0x40.
- Same with DELAY_SLOT_EN -> IF/ID gets word at 0x10, next imem_addr=0x40; with ack delayed 2 cycles, 0x10 completes before 0x40 issued.
- branch_taken with stall_ctrl=1 -> redirect ignored, pc unchanged; RESET_PC=0xFFFF_FFFC -> next pc 0x0.
- rst pulsed while ack outstanding -> outputs return to reset values; first post-reset request at RESET_PC.
